// File: rtl/pc88_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc88_loader_ctrl
// Brief    : Queues HPS ioctl download bytes and replays them to the PC88
//            loader port using a request/acknowledge handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pc88_loader_ctrl #(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 4,
    parameter int ACK_TO = 4095
) (
    input  logic              clk_sys,
    input  logic              rstn,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ldr_adr,
    output logic [7:0]        ldr_wdat,
    output logic              ldr_wr,
    input  logic              ldr_ack,
    output logic              ldr_oe,
    output logic              ldr_done,
    output logic [7:0]        ldr_index,
    output logic              ldr_err
);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_to_w  = $clog2(ACK_TO + 1);
    localparam int c_ent_w = ADDR_W + 8;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_wait_cnt = c_cnt_w'(DEPTH - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(ACK_TO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_ent_w-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [c_to_w-1:0]    to_cnt_q, to_cnt_d;
    logic [ADDR_W-1:0]    adr_q, adr_d;
    logic [7:0]           wdat_q, wdat_d, index_q, index_d;
    logic                 wait_q, wait_d, wr_q, wr_d, done_q, done_d;
    logic                 err_q, err_d, started_q, started_d;
    logic                 old_ack_q, old_dl_q;

    logic                 w_full, w_empty, w_push, w_pop, w_overflow;
    logic                 w_ack_edge, w_dl_rise;
    logic [c_ent_w-1:0]   w_head;

    generate
        if (ADDR_W < 25) begin : g_unused_addr
            logic w_unused;
            assign w_unused = &{1'b0, ioctl_addr[24:ADDR_W]};
        end
    endgenerate

    always_comb begin
        w_full     = (count_q == c_full_cnt);
        w_empty    = (count_q == '0);
        w_ack_edge = ldr_ack & ~old_ack_q;
        w_dl_rise  = ioctl_download & ~old_dl_q;
        w_push     = ioctl_wr & ioctl_download & ~w_full;
        w_overflow = ioctl_wr & ioctl_download & w_full;
        w_head     = mem_q[rd_ptr_q];
        w_pop      = 1'b0;

        state_d   = state_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        wr_d      = wr_q;
        to_cnt_d  = to_cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        index_d   = index_q;
        started_d = started_q;

        // A new download session re-arms the status flags from any state.
        if (w_dl_rise) begin
            index_d   = ioctl_index;
            done_d    = 1'b0;
            err_d     = 1'b0;
            started_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DRAIN: begin
                if (!w_empty) begin
                    adr_d    = w_head[c_ent_w-1:8];
                    wdat_d   = w_head[7:0];
                    wr_d     = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_REQ;
                end else if (state_q == S_DRAIN) begin
                    if (ioctl_download) begin
                        state_d = S_IDLE;
                    end else if (!wr_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        started_d = 1'b0;
                    end
                end else if (started_q && !ioctl_download) begin
                    state_d = S_DRAIN;
                end
            end
            S_REQ: begin
                if (w_ack_edge || (to_cnt_q == c_to_last)) begin
                    w_pop   = 1'b1;
                    wr_d    = 1'b0;
                    state_d = ioctl_download ? S_IDLE : S_DRAIN;
                    if (!w_ack_edge) begin
                        err_d = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (w_dl_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_overflow) begin
            err_d = 1'b1;
        end

        wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wait_d = (count_d >= c_wait_cnt);
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            to_cnt_q  <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            index_q   <= '0;
            wait_q    <= 1'b0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            started_q <= 1'b0;
            old_ack_q <= 1'b0;
            old_dl_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            to_cnt_q  <= to_cnt_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            index_q   <= index_d;
            wait_q    <= wait_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            started_q <= started_d;
            old_ack_q <= ldr_ack;
            old_dl_q  <= ioctl_download;
        end
    end

    assign ioctl_wait = wait_q;
    assign ldr_adr    = adr_q;
    assign ldr_wdat   = wdat_q;
    assign ldr_wr     = wr_q;
    assign ldr_done   = done_q;
    assign ldr_index  = index_q;
    assign ldr_err    = err_q;
    // Gated by rstn so the bus is released during reset even if a download is active.
    assign ldr_oe     = rstn & (ioctl_download | ~w_empty | wr_q) & ~done_q;

endmodule
`default_nettype wire

// File: tb/tb_pc88_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc88_loader_ctrl
// Brief    : Directed self-checking bench for pc88_loader_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc88_loader_ctrl;
    logic        clk_sys;
    logic        rstn;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [18:0] ldr_adr;
    logic [7:0]  ldr_wdat;
    logic        ldr_wr;
    logic        ldr_ack;
    logic        ldr_oe;
    logic        ldr_done;
    logic [7:0]  ldr_index;
    logic        ldr_err;

    int checks = 0;
    int passes = 0;

    pc88_loader_ctrl #(
        .ADDR_W (19),
        .DEPTH  (4),
        .ACK_TO (15)
    ) dut (
        .clk_sys        (clk_sys),
        .rstn           (rstn),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ldr_adr        (ldr_adr),
        .ldr_wdat       (ldr_wdat),
        .ldr_wr         (ldr_wr),
        .ldr_ack        (ldr_ack),
        .ldr_oe         (ldr_oe),
        .ldr_done       (ldr_done),
        .ldr_index      (ldr_index),
        .ldr_err        (ldr_err)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic hps_write(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack_now();
        ldr_ack = 1'b1;
        tick();
        ldr_ack = 1'b0;
    endtask

    task automatic wait_wr(input int budget, input string tag);
        int n = 0;
        while (!ldr_wr && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(ldr_wr), 32'd1);
    endtask

    initial begin
        int sent;
        int got;
        int hi;
        int seen;

        rstn           = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        ldr_ack        = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_wait",  32'(ioctl_wait), 32'd0);
        chk("rst_wr",    32'(ldr_wr),     32'd0);
        chk("rst_oe",    32'(ldr_oe),     32'd0);
        chk("rst_done",  32'(ldr_done),   32'd0);
        chk("rst_err",   32'(ldr_err),    32'd0);
        chk("rst_adr",   32'(ldr_adr),    32'd0);
        chk("rst_wdat",  32'(ldr_wdat),   32'd0);
        chk("rst_index", 32'(ldr_index),  32'd0);
        tick();
        tick();
        rstn = 1'b1;

        // Basic load: three bytes, acked four cycles after each request
        ioctl_index    = 8'h01;
        ioctl_download = 1'b1;
        tick();
        chk("basic_index", 32'(ldr_index), 32'h01);
        chk("basic_oe",    32'(ldr_oe),    32'd1);
        hps_write(25'h0, 8'hA5);
        hps_write(25'h1, 8'h5A);
        hps_write(25'h2, 8'hFF);
        chk("basic_wait3", 32'(ioctl_wait), 32'd1);
        ioctl_download = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == 0) ? 8'hA5 : (i == 1) ? 8'h5A : 8'hFF;
            chk("basic_adr",  32'(ldr_adr),  32'(i));
            chk("basic_wdat", 32'(ldr_wdat), 32'(exp_d));
            tick(); tick(); tick();
            chk("basic_hold", 32'(ldr_wr), 32'd1);
            ack_now();
            chk("basic_drop", 32'(ldr_wr), 32'd0);
            if (i == 0) chk("basic_wait2", 32'(ioctl_wait), 32'd0);
            if (i < 2) begin
                tick();
                chk("basic_next", 32'(ldr_wr), 32'd1);
            end
        end
        chk("basic_done_early", 32'(ldr_done), 32'd0);
        tick();
        chk("basic_done",  32'(ldr_done),  32'd1);
        chk("basic_oe_off",32'(ldr_oe),    32'd0);
        chk("basic_err",   32'(ldr_err),   32'd0);
        chk("basic_idx2",  32'(ldr_index), 32'h01);

        // Backpressure: HPS honours ioctl_wait, core acks from cycle 10 on
        ioctl_index    = 8'h03;
        ioctl_download = 1'b1;
        tick();
        chk("bp_rearm", 32'(ldr_done), 32'd0);
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            ioctl_wr   = (sent < 8) && !ioctl_wait;
            ioctl_addr = 25'(32'h100 + sent);
            ioctl_dout = 8'(8'h10 + sent);
            ldr_ack    = (cyc >= 10) && ldr_wr;
            if (ldr_ack) begin
                chk("bp_adr",  32'(ldr_adr),  32'h100 + 32'(got));
                chk("bp_wdat", 32'(ldr_wdat), 32'h10 + 32'(got));
                got++;
            end
            if (ioctl_wr) sent++;
            tick();
            if (cyc == 2) chk("bp_wait", 32'(ioctl_wait), 32'd1);
        end
        ioctl_wr = 1'b0;
        ldr_ack  = 1'b0;
        chk("bp_count", 32'(got), 32'd8);
        chk("bp_err",   32'(ldr_err), 32'd0);
        tick();

        // Overflow: six writes, no ack; last two are dropped
        for (int i = 0; i < 6; i++) begin
            hps_write(25'(32'h200 + i), 8'(8'hC0 + i));
            if (i == 3) chk("ovf_err_before", 32'(ldr_err), 32'd0);
        end
        chk("ovf_err",  32'(ldr_err),    32'd1);
        chk("ovf_wait", 32'(ioctl_wait), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_wr(5, "ovf_req");
            chk("ovf_adr",  32'(ldr_adr),  32'h200 + 32'(i));
            chk("ovf_wdat", 32'(ldr_wdat), 32'hC0 + 32'(i));
            ack_now();
        end
        tick(); tick(); tick(); tick();
        chk("ovf_no5th", 32'(ldr_wr), 32'd0);

        // Timeout: one byte never acknowledged
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("to_prev_done", 32'(ldr_done), 32'd1);
        ioctl_index    = 8'h04;
        ioctl_download = 1'b1;
        tick();
        chk("to_err_clr", 32'(ldr_err), 32'd0);
        hps_write(25'h300, 8'h77);
        wait_wr(4, "to_req");
        ioctl_download = 1'b0;
        hi = 0;
        for (int k = 0; k < 40 && ldr_wr; k++) begin
            hi++;
            tick();
        end
        chk("to_len", 32'(hi), 32'd15);
        chk("to_err", 32'(ldr_err), 32'd1);
        tick();
        chk("to_done", 32'(ldr_done), 32'd1);

        // Early download end with held ack, then re-arm with index 0x02
        ioctl_index    = 8'h02;
        ioctl_download = 1'b1;
        tick();
        chk("ee_done_clr", 32'(ldr_done),  32'd0);
        chk("ee_err_clr",  32'(ldr_err),   32'd0);
        chk("ee_index",    32'(ldr_index), 32'h02);
        hps_write(25'h400, 8'h11);
        hps_write(25'h401, 8'h22);
        ioctl_download = 1'b0;
        chk("ee_oe1",  32'(ldr_oe),   32'd1);
        chk("ee_adr0", 32'(ldr_adr),  32'h400);
        chk("ee_dat0", 32'(ldr_wdat), 32'h11);
        ldr_ack = 1'b1;
        tick();
        chk("ee_pop0", 32'(ldr_wr), 32'd0);
        chk("ee_oe2",  32'(ldr_oe), 32'd1);
        tick();
        chk("ee_adr1", 32'(ldr_adr),  32'h401);
        chk("ee_dat1", 32'(ldr_wdat), 32'h22);
        tick(); tick(); tick();
        chk("ee_held_ack", 32'(ldr_wr), 32'd1);
        chk("ee_oe3",      32'(ldr_oe), 32'd1);
        ldr_ack = 1'b0;
        tick();
        chk("ee_still", 32'(ldr_wr), 32'd1);
        ldr_ack = 1'b1;
        tick();
        ldr_ack = 1'b0;
        chk("ee_pop1",  32'(ldr_wr),   32'd0);
        chk("ee_ndone", 32'(ldr_done), 32'd0);
        tick();
        chk("ee_done",  32'(ldr_done), 32'd1);
        chk("ee_oe0",   32'(ldr_oe),   32'd0);

        // Reset while a request is pending with more bytes queued
        ioctl_index    = 8'h05;
        ioctl_download = 1'b1;
        tick();
        hps_write(25'h500, 8'h31);
        hps_write(25'h501, 8'h32);
        hps_write(25'h502, 8'h33);
        chk("rr_wr_pre",   32'(ldr_wr),     32'd1);
        chk("rr_wait_pre", 32'(ioctl_wait), 32'd1);
        #3 rstn = 1'b0;
        #1;
        chk("rr_wr",   32'(ldr_wr),     32'd0);
        chk("rr_oe",   32'(ldr_oe),     32'd0);
        chk("rr_wait", 32'(ioctl_wait), 32'd0);
        chk("rr_adr",  32'(ldr_adr),    32'd0);
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ldr_wr) seen++;
        end
        chk("rr_no_req", 32'(seen), 32'd0);
        hps_write(25'h5AA, 8'h99);
        tick();
        chk("rr_new_wr",  32'(ldr_wr),   32'd1);
        chk("rr_new_adr", 32'(ldr_adr),  32'h5AA);
        chk("rr_new_dat", 32'(ldr_wdat), 32'h99);
        ack_now();
        chk("rr_new_pop", 32'(ldr_wr), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
